keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Bus-read input peripheral: scans a 4x4 matrix keypad, debounces presses, and queues 4-bit key codes in a small FIFO.
//  The CPU reads the codes over the same ce/we/ack slave interface used by the seven-segment display driver.
//  The code format (0x0-0xF) is the same nibble the display driver accepts, so software can echo keys directly.
// PARAMETERS
//  SCAN_DIV      1000  clocks each column stays driven; row_i is sampled on the last cycle of that column
//  DEBOUNCE_CNT  4     consecutive identical frames needed to accept a press or a release
//  FIFO_DEPTH    4     key-code queue entries; must be a power of 2
// PORTS
//  clk     in   1  system clock
//  rst     in   1  synchronous, active-low reset (rst==1'b0 resets on the clk edge)
//  col_o   out  4  column drive, active-low, one-hot-low
//  row_i   in   4  row sense, active-low (pulled up externally), asynchronous
//  ce      in   1  chip enable from the bus
//  we      in   1  1 = write, 0 = read
//  data_i  in   8  write data; bit0=1 flushes the FIFO and clears overflow
//  data_o  out  8  read data: {valid, overflow, 2'b00, code[3:0]}
//  ack     out  1  tied to 1'b1 (zero-wait slave)
// BEHAVIOUR
//  Reset values: col_o=4'b1110, column counter 0, divider 0, FSM IDLE, debounce counter 0, FIFO empty, overflow 0,
//    both synchroniser stages 4'b1111.
//  row_i passes through a 2-flop synchroniser. Column c is held for SCAN_DIV cycles with col_o=~(4'b1<<c), then c wraps 3->0.
//  Sampling: at the last divider cycle of column c, snap[c*4+r] = ~row_sync[r].
//  Frame: ends after column 3 is sampled; frame length is 4*SCAN_DIV cycles.
//  Each frame is classified as NONE (0 keys), ONE (exactly one key, code={row[1:0],col[1:0]}), or MULTI (2+ keys).
//  Debounce FSM, evaluated once per frame end:
//   IDLE:    ONE -> CAND, cnt=1, latch code. NONE/MULTI -> stay in IDLE.
//   CAND:    ONE with same code -> cnt++; when cnt reaches DEBOUNCE_CNT, push code and go to PRESSED.
//            ONE with a different code -> restart CAND with cnt=1 and the new code.
//            NONE/MULTI -> IDLE.
//   PRESSED: NONE -> RELEASE, cnt=1. ONE/MULTI -> stay; no repeat pushes.
//   RELEASE: NONE -> cnt++; when cnt reaches DEBOUNCE_CNT, go to IDLE. ONE/MULTI -> PRESSED.
//  Latency: from a stable press to the push = up to (DEBOUNCE_CNT+1) frames, plus 2 sync cycles.
//  Read: a read strobe is ce&~we. Combinationally, data_o={~empty, overflow, 2'b00, head code}.
//    Code bits read 0 when the FIFO is empty. data_o=8'h00 whenever ce==0 or we==1.
//  Pop: happens on the clk edge of the FIRST cycle of a read strobe, if the FIFO is not empty.
//    A strobe held for N cycles pops once. Overflow clears on that same edge.
//  Push when full: the code is dropped and overflow<=1 (sticky).
//    Exception: if a pop occurs on the same edge, the push succeeds and overflow is not set.
//  Simultaneous push and pop on a non-full FIFO: both take effect; the count is unchanged.
//  Write strobe (ce&we) with data_i[0]=1: FIFO emptied and overflow cleared.
//    A push on the same edge is discarded (flush wins). A write with data_i[0]=0 has no effect.
//  Reset asserted mid-scan or mid-debounce: everything returns to reset values on that edge and no partial press is pushed.
//  Widths: divider is $clog2(SCAN_DIV) bits, debounce counter $clog2(DEBOUNCE_CNT+1) bits, FIFO pointers log2(DEPTH)+1 bits.
// STRUCTURE
//  defines.v: `KeyDataBus 7:0, `KeyCodeBus 3:0, `KeyStIdle/`KeyStCand/`KeyStPressed/`KeyStRelease (2-bit encodings),
//    `KeyFlushBit 0.
//  Sub-module key_fifo (clk, rst, push, pop, flush, din[3:0], dout[3:0], empty, full).
//    It is a synchronous FIFO with show-ahead (head visible on dout).
//  Top level holds the synchroniser, column divider/counter, snapshot register, frame classifier, debounce FSM,
//    and the bus decode with read-edge detect.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_CNT=2; frame = 16 cycles)
//  1. Hold rst=0 for 3 cycles, then read -> col_o=4'b1110, data_o=8'h00, ack=1.
//  2. Press row2/col1 (row_i[2]=0 only while col_o[1]=0) for 4 frames, then read -> data_o=8'h89.
//     A second read returns 8'h00.
//  3. Key present for 1 frame, absent for 1, repeated 6 times -> FIFO never leaves empty; reads return 8'h00.
//  4. Hold row0/col0 for 20 frames, release for 3 frames -> exactly one entry; reads give 8'h80 then 8'h00.
//  5. Press/release keys 1,2,3,4,5 (each 3 frames on, 3 off) with no reads.
//     Reads -> 8'hC1, 8'h82, 8'h83, 8'h84, 8'h00 (5th dropped; overflow cleared by the first read).
//  6. Hold ce=1, we=0 for 5 cycles with 2 entries queued -> only one pop.
//     Then a write with data_i=8'h01 -> next read returns 8'h00.
//     Then press two keys in one column -> no push.
//     Then assert rst during CAND -> no push afterwards.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the keypad scanner slice.
// Bus layout, key codes and debounce state encodings.
package keypad_scanner_pkg;

  localparam int KEY_DATA_W    = 8;
  localparam int KEY_CODE_W    = 4;
  localparam int KEY_FLUSH_BIT = 0;

  typedef logic [KEY_DATA_W-1:0] key_data_t;
  typedef logic [KEY_CODE_W-1:0] key_code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAND    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_RELEASE = 2'd3
  } key_st_e;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_ONE   = 2'd1,
    CLS_MULTI = 2'd2
  } frame_cls_e;

endpackage

// File: rtl/keypad_scanner_if.sv
// Zero-wait ce/we/ack slave bus shared with the display driver.
// The CPU side is the master, peripherals use the slave view.
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  logic      ce;
  logic      we;
  key_data_t data_i;
  key_data_t data_o;
  logic      ack;

  modport master (
    output ce, we, data_i,
    input  data_o, ack
  );

  modport slave (
    input  ce, we, data_i,
    output data_o, ack
  );

endinterface

// File: rtl/keypad_scanner_fifo.sv
// Show-ahead synchronous FIFO for key codes.
// Flush wins over push/pop; a push into a full FIFO survives a same-edge pop.
module key_fifo
  import keypad_scanner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  key_code_t din,
  output key_code_t dout,
  output logic      empty,
  output logic      full
);

  localparam int AW = $clog2(DEPTH);

  key_code_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, frame debounce, key-code FIFO.
// Codes are read over the ce/we/ack slave bus as {valid, overflow, 00, code}.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       col_o,
  input  logic [3:0]       row_i,
  keypad_scanner_if.slave  bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]       row_s1;
  logic [3:0]       row_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [15:0]      snap;
  logic [15:0]      snap_nxt;
  logic             div_last;
  logic             frame_end;

  frame_cls_e       cls;
  key_code_t        frame_code;
  logic [4:0]       n_keys;

  key_st_e          st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  key_code_t        cand, cand_n;
  logic             push;

  logic             rd, rd_q, wr, flush;
  logic             pop;
  logic             ovf;
  logic             empty, full;
  key_code_t        head;
  logic             unused_bits;

  assign div_last  = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_end = div_last && (col == 2'd3);
  assign col_o     = ~(4'b0001 << col);

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
      div    <= '0;
      col    <= 2'd0;
      snap   <= '0;
    end else begin
      row_s1 <= row_i;
      row_s2 <= row_s1;
      div    <= div_last ? '0 : div + 1'b1;
      col    <= div_last ? col + 2'd1 : col;
      snap   <= snap_nxt;
    end
  end

  // The classifier must see column 3's sample in the frame-end cycle.
  always_comb begin
    snap_nxt = snap;
    if (div_last)
      snap_nxt[{col, 2'b00} +: 4] = ~row_s2;
  end

  always_comb begin
    n_keys     = '0;
    frame_code = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (snap_nxt[c*4 + r]) begin
          n_keys     = n_keys + 5'd1;
          frame_code = {r[1:0], c[1:0]};
        end
      end
    end
    unique case (1'b1)
      (n_keys == 5'd0): cls = CLS_NONE;
      (n_keys == 5'd1): cls = CLS_ONE;
      default:          cls = CLS_MULTI;
    endcase
  end

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      st   <= ST_IDLE;
      cnt  <= '0;
      cand <= '0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      cand <= cand_n;
    end
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    cand_n = cand;
    push   = 1'b0;
    if (frame_end) begin
      unique case (st)
        ST_IDLE: begin
          if (cls == CLS_ONE) begin
            st_n   = ST_CAND;
            cnt_n  = CNT_W'(1);
            cand_n = frame_code;
          end
        end
        ST_CAND: begin
          if (cls != CLS_ONE) begin
            st_n = ST_IDLE;
          end else if (frame_code != cand) begin
            cnt_n  = CNT_W'(1);
            cand_n = frame_code;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
              push = 1'b1;
              st_n = ST_PRESSED;
            end
          end
        end
        ST_PRESSED: begin
          if (cls == CLS_NONE) begin
            st_n  = ST_RELEASE;
            cnt_n = CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cls != CLS_NONE) begin
            st_n = ST_PRESSED;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_CNT))
              st_n = ST_IDLE;
          end
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end

  assign rd    = bus.ce & ~bus.we;
  assign wr    = bus.ce & bus.we;
  assign flush = wr & bus.data_i[KEY_FLUSH_BIT];
  assign pop   = rd & ~rd_q & ~empty;

  assign unused_bits = ^bus.data_i[KEY_DATA_W-1:1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      rd_q <= rd;
      if (flush)
        ovf <= 1'b0;
      else if (push && full && !pop)
        ovf <= 1'b1;
      else if (pop)
        ovf <= 1'b0;
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (cand),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

  assign bus.data_o = rd ? {~empty, ovf, 2'b00, (empty ? 4'h0 : head)}
                         : 8'h00;
  assign bus.ack    = 1'b1;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Key index = row*4 + col, matching the reported key code.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col_o;
  logic [3:0]  row_i;
  logic [15:0] keys = '0;
  int          checks = 0;
  int          failures = 0;

  keypad_scanner_if bus_if ();

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (2),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .col_o (col_o),
    .row_i (row_i),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_i = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_o[c] && keys[r*4 + c])
          row_i[r] = 1'b0;
  end

  task automatic next_frame();
    logic [3:0] p;
    int n;
    p = col_o;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (p == 4'b0111 && col_o == 4'b1110) break;
      if (n > 100) begin
        failures++;
        $display("FAIL frame_wait: no frame start after %0d cycles", n);
        break;
      end
      p = col_o;
    end
  endtask

  task automatic do_read(input logic [7:0] exp, input string name);
    @(negedge clk);
    bus_if.ce = 1'b1;
    bus_if.we = 1'b0;
    #1;
    checks++;
    if (bus_if.data_o !== exp) begin
      failures++;
      $display("FAIL %s: data_o=%h expected %h", name, bus_if.data_o, exp);
    end
    @(negedge clk);
    bus_if.ce = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] d);
    @(negedge clk);
    bus_if.ce     = 1'b1;
    bus_if.we     = 1'b1;
    bus_if.data_i = d;
    #1;
    checks++;
    if (bus_if.data_o !== 8'h00) begin
      failures++;
      $display("FAIL write_data_o: data_o=%h expected 00", bus_if.data_o);
    end
    @(negedge clk);
    bus_if.ce     = 1'b0;
    bus_if.we     = 1'b0;
    bus_if.data_i = 8'h00;
  endtask

  task automatic press(input int code, input int on, input int off);
    keys = 16'(1) << code;
    repeat (on) next_frame();
    keys = '0;
    repeat (off) next_frame();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus_if.ce = 1'b1;
    bus_if.we = 1'b0;
    #1;
    checks++;
    if (col_o !== 4'b1110) begin
      failures++;
      $display("FAIL reset_col: col_o=%b expected 1110", col_o);
    end
    checks++;
    if (bus_if.data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: data_o=%h expected 00", bus_if.data_o);
    end
    checks++;
    if (bus_if.ack !== 1'b1) begin
      failures++;
      $display("FAIL reset_ack: ack=%b expected 1", bus_if.ack);
    end
    @(negedge clk);
    bus_if.ce = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_single_press();
    repeat (2) next_frame();
    press(9, 4, 0);
    do_read(8'h89, "press_r2c1");
    do_read(8'h00, "press_second_read");
    repeat (3) next_frame();
  endtask

  task automatic test_bounce();
    next_frame();
    for (int i = 0; i < 6; i++) press(6, 1, 1);
    do_read(8'h00, "bounce_empty");
    next_frame();
  endtask

  task automatic test_hold();
    next_frame();
    press(0, 20, 3);
    do_read(8'h80, "hold_one_entry");
    do_read(8'h00, "hold_no_repeat");
  endtask

  task automatic test_overflow();
    next_frame();
    for (int k = 1; k <= 5; k++) press(k, 3, 3);
    do_read(8'hC1, "ovf_first");
    do_read(8'h82, "ovf_second");
    do_read(8'h83, "ovf_third");
    do_read(8'h84, "ovf_fourth");
    do_read(8'h00, "ovf_drained");
  endtask

  task automatic test_back_to_back();
    next_frame();
    press(6, 3, 3);
    press(10, 3, 3);
    press(12, 3, 3);
    @(negedge clk);
    bus_if.ce = 1'b1;
    bus_if.we = 1'b0;
    #1;
    checks++;
    if (bus_if.data_o !== 8'h86) begin
      failures++;
      $display("FAIL hold_read_first: data_o=%h expected 86", bus_if.data_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus_if.data_o !== 8'h8A) begin
        failures++;
        $display("FAIL hold_read_one_pop: data_o=%h expected 8a",
                 bus_if.data_o);
      end
    end
    @(negedge clk);
    bus_if.ce = 1'b0;
    do_write(8'h00);
    do_read(8'h8A, "write_no_flush");
    do_write(8'h01);
    do_read(8'h00, "flush_empty");
  endtask

  task automatic test_multi();
    next_frame();
    keys = (16'(1) << 1) | (16'(1) << 9);
    repeat (4) next_frame();
    keys = '0;
    repeat (3) next_frame();
    do_read(8'h00, "multi_no_push");
  endtask

  task automatic test_reset_mid();
    next_frame();
    keys = 16'(1) << 5;
    next_frame();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (col_o !== 4'b1110) begin
      failures++;
      $display("FAIL mid_reset_col: col_o=%b expected 1110", col_o);
    end
    rst = 1'b1;
    next_frame();
    keys = '0;
    repeat (3) next_frame();
    do_read(8'h00, "mid_reset_no_push");
  endtask

  initial begin
    bus_if.ce     = 1'b0;
    bus_if.we     = 1'b0;
    bus_if.data_i = 8'h00;
    test_reset();
    test_single_press();
    test_bounce();
    test_hold();
    test_overflow();
    test_back_to_back();
    test_multi();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
